// File: rtl/top_mole99_pkg.sv
// Shared VGA 640x480@60 timing constants, sprite geometry and artwork for top_mole99.
package top_mole99_pkg;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_TOTAL      = 10'd800;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_TOTAL      = 10'd525;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int         SPRITE_SIZE  = 16;
  localparam int         SPRITE_SCALE = 4;
  localparam logic [9:0] SPRITE_PIX   = 10'(SPRITE_SIZE * SPRITE_SCALE);

  localparam logic [9:0] X_MAX   = 10'd576;
  localparam logic [9:0] Y_MAX   = 10'd416;
  localparam logic [9:0] X_RESET = 10'd288;
  localparam logic [9:0] Y_RESET = 10'd208;

  typedef logic [5:0] rgb_t;

  // Pony facing right; bit 15 of each row is the leftmost column.
  localparam logic [15:0] SPRITE_BITMAP [SPRITE_SIZE] = '{
    16'b0000_0000_0110_0000,
    16'b0000_0000_1111_0000,
    16'b0000_0001_1111_1000,
    16'b0000_0011_1101_1100,
    16'b0000_0111_1111_1110,
    16'b0000_1111_1110_0110,
    16'b0001_1111_1100_0000,
    16'b0111_1111_1100_0000,
    16'b1111_1111_1100_0000,
    16'b1111_1111_1000_0000,
    16'b0111_1111_1000_0000,
    16'b0011_0000_1100_0000,
    16'b0011_0000_1100_0000,
    16'b0011_0000_1100_0000,
    16'b0011_0000_1100_0000,
    16'b0111_0001_1100_0000
  };

  // TinyVGA Pmod pin order: {hs, B0, G0, R0, vs, B1, G1, R1}.
  function automatic logic [7:0] pack_pins(input rgb_t c, input logic hs_n, input logic vs_n);
    return {hs_n, c[0], c[2], c[4], vs_n, c[1], c[3], c[5]};
  endfunction

endpackage

// File: rtl/top_mole99_vga_timing.sv
// Horizontal/vertical pixel counters with sync and visible-area decode.
module vga_timing
  import top_mole99_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       visible
);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (hcount_q == H_TOTAL - 10'd1) begin
      hcount_d = 10'd0;
      if (vcount_q == V_TOTAL - 10'd1) begin
        vcount_d = 10'd0;
      end else begin
        vcount_d = vcount_q + 10'd1;
      end
    end else begin
      hcount_d = hcount_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hcount  = hcount_q;
  assign vcount  = vcount_q;
  assign hsync_n = !((hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END));
  assign vsync_n = !((vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END));
  assign visible = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);

endmodule

// File: rtl/top_mole99.sv
// Bouncing 64x64 pony sprite over a programmable background on TinyVGA pins.
// Optional feature macro: SPRITE_MIRROR_EN (face the direction of travel).
module top_mole99
  import top_mole99_pkg::*;
(
`ifdef USE_POWER_PINS
  inout  wire        VPWR,
  inout  wire        VGND,
`endif
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [9:0] hcount_s, vcount_s;
  logic       hsync_n_s, vsync_n_s, visible_s;

  vga_timing u_timing (
    .clk     (clk),
    .rst_n   (rst_n),
    .hcount  (hcount_s),
    .vcount  (vcount_s),
    .hsync_n (hsync_n_s),
    .vsync_n (vsync_n_s),
    .visible (visible_s)
  );

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic       upd_s;
  logic [7:0] uo_q, uo_d;

  // Once per frame, at the start of vertical blanking, unless paused.
  assign upd_s = (hcount_s == 10'd0) && (vcount_s == V_VISIBLE) && !ui_in[6];

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (upd_s) begin
      if (dx_q) begin
        if (x_q == X_MAX) begin
          dx_d = 1'b0;
          x_d  = x_q - 10'd1;
        end else begin
          x_d  = x_q + 10'd1;
        end
      end else begin
        if (x_q == 10'd0) begin
          dx_d = 1'b1;
          x_d  = x_q + 10'd1;
        end else begin
          x_d  = x_q - 10'd1;
        end
      end
      if (dy_q) begin
        if (y_q == Y_MAX) begin
          dy_d = 1'b0;
          y_d  = y_q - 10'd1;
        end else begin
          y_d  = y_q + 10'd1;
        end
      end else begin
        if (y_q == 10'd0) begin
          dy_d = 1'b1;
          y_d  = y_q + 10'd1;
        end else begin
          y_d  = y_q - 10'd1;
        end
      end
    end else begin
      x_d = x_q;
    end
  end

  logic [9:0]  hoff_s, voff_s;
  logic        in_spr_s, pix_on_s;
  logic [3:0]  col_raw_s, col_s, row_s;
  logic [15:0] row_bits_s;
  rgb_t        rgb_s;

  // Offsets wrap when left/above the sprite, so the >= guard is needed too.
  always_comb begin
    hoff_s     = hcount_s - x_q;
    voff_s     = vcount_s - y_q;
    in_spr_s   = (hcount_s >= x_q) && (hoff_s < SPRITE_PIX) &&
                 (vcount_s >= y_q) && (voff_s < SPRITE_PIX);
    col_raw_s  = hoff_s[5:2];
    row_s      = voff_s[5:2];
`ifdef SPRITE_MIRROR_EN
    col_s      = dx_q ? col_raw_s : (4'd15 - col_raw_s);
`else
    col_s      = col_raw_s;
`endif
    row_bits_s = SPRITE_BITMAP[row_s];
    pix_on_s   = in_spr_s && row_bits_s[4'd15 - col_s];
    if (!visible_s) begin
      rgb_s = 6'd0;
    end else if (pix_on_s) begin
      rgb_s = ui_in[5:0];
    end else begin
      rgb_s = uio_in[5:0];
    end
    uo_d = pack_pins(rgb_s, hsync_n_s, vsync_n_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= X_RESET;
      y_q  <= Y_RESET;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
      uo_q <= 8'h88;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      uo_q <= uo_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = 8'd0;
  assign uio_oe  = 8'd0;

  logic unused_s;
  assign unused_s = &{1'b0, ena, ui_in[7], uio_in[7:6]};

endmodule

// File: tb/tb_top_mole99.sv
// Randomized bench for top_mole99 against a frame-level behavioural model.
module tb_top_mole99;
  import top_mole99_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out, uio_out, uio_oe;
`ifdef USE_POWER_PINS
  wire vpwr = 1'b1;
  wire vgnd = 1'b0;
`endif

  top_mole99 dut (
`ifdef USE_POWER_PINS
    .VPWR    (vpwr),
    .VGND    (vgnd),
`endif
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state: scan position and sprite origin/direction
  int mh, mv, mx, my;
  bit mdx, mdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d)", tag, got, want, mh, mv);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; mx = 288; my = 208; mdx = 1'b1; mdy = 1'b1;
  endtask

  function automatic logic [7:0] model_pix(int h, int v, logic [5:0] spr, logic [5:0] bg);
    logic [5:0]  c;
    logic [15:0] bits;
    int          col, row;
    c = 6'd0;
    if (h < 640 && v < 480) begin
      c = bg;
      if (h >= mx && h < mx + 64 && v >= my && v < my + 64) begin
        col = (h - mx) / 4;
        row = (v - my) / 4;
`ifdef SPRITE_MIRROR_EN
        if (!mdx) col = 15 - col;
`endif
        bits = SPRITE_BITMAP[row];
        if (bits[15 - col]) c = spr;
      end
    end
    return {(h >= 656 && h < 752) ? 1'b0 : 1'b1, c[0], c[2], c[4],
            (v >= 490 && v < 492) ? 1'b0 : 1'b1, c[1], c[3], c[5]};
  endfunction

  task automatic model_advance(input bit pause);
    if (mh == 0 && mv == 480 && !pause) begin
      if (mdx) begin
        if (mx == 576) begin mdx = 1'b0; mx = 575; end else mx = mx + 1;
      end else begin
        if (mx == 0) begin mdx = 1'b1; mx = 1; end else mx = mx - 1;
      end
      if (mdy) begin
        if (my == 416) begin mdy = 1'b0; my = 415; end else my = my + 1;
      end else begin
        if (my == 0) begin mdy = 1'b1; my = 1; end else my = my - 1;
      end
    end
    mh = mh + 1;
    if (mh == 800) begin
      mh = 0;
      mv = (mv == 524) ? 0 : mv + 1;
    end
  endtask

  // Called at a negedge: drive inputs, predict the next registered output, check at next negedge.
  task automatic step(input logic [7:0] ui, input logic [7:0] uio);
    logic [7:0] exp;
    ui_in  = ui;
    uio_in = uio;
    exp = model_pix(mh, mv, ui[5:0], uio[5:0]);
    model_advance(ui[6]);
    @(negedge clk);
    check_eq("pix", {24'd0, uo_out}, {24'd0, exp});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(8'($urandom), 8'($urandom));
  endtask

  task automatic run_p(input int n, input bit p);
    logic [7:0] r;
    for (int i = 0; i < n; i++) begin
      r = 8'($urandom);
      step({r[7], p, r[5:0]}, 8'($urandom));
    end
  endtask

  task automatic jump(input int h, input int v);
    force dut.u_timing.hcount_q = 10'(h);
    force dut.u_timing.vcount_q = 10'(v);
    #1;
    release dut.u_timing.hcount_q;
    release dut.u_timing.vcount_q;
    mh = h; mv = v;
  endtask

  task automatic set_sprite(input int x, input int y, input bit dx, input bit dy);
    force dut.x_q  = 10'(x);
    force dut.y_q  = 10'(y);
    force dut.dx_q = dx;
    force dut.dy_q = dy;
    #1;
    release dut.x_q;
    release dut.y_q;
    release dut.dx_q;
    release dut.dy_q;
    mx = x; my = y; mdx = dx; mdy = dy;
  endtask

  task automatic check_sprite(input string tag, input int x, input int y, input bit dx, input bit dy);
    check_eq({tag, "_x"}, {22'd0, dut.x_q}, 32'(x));
    check_eq({tag, "_y"}, {22'd0, dut.y_q}, 32'(y));
    check_eq({tag, "_dir"}, {30'd0, dut.dx_q, dut.dy_q}, {30'd0, dx, dy});
  endtask

  initial begin
    int  k_first, k_second, low_len, vs_low;
    bit  prev;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_uo", {24'd0, uo_out}, 32'h88);
    check_eq("rst_uio_out", {24'd0, uio_out}, 32'h0);
    check_eq("rst_uio_oe", {24'd0, uio_oe}, 32'h0);
    rst_n = 1'b1;

    // hsync timing over the first two lines
    k_first = -1; k_second = -1; low_len = 0; prev = 1'b1;
    for (int k = 1; k <= 1700; k++) begin
      step(8'($urandom), 8'($urandom));
      if (!uo_out[7]) begin
        if (prev) begin
          if (k_first < 0) k_first = k;
          else if (k_second < 0) k_second = k;
        end
        if (k_second < 0) low_len++;
      end
      prev = uo_out[7];
    end
    check_eq("hs_first", 32'(k_first), 32'd657);
    check_eq("hs_period", 32'(k_second - k_first), 32'd800);
    check_eq("hs_width", 32'(low_len), 32'd96);

    // directed colour points
    jump(100, 100); step(8'h00, 8'h30);
    check_eq("bg", {24'd0, uo_out & 8'h77}, 32'h11);
    jump(320, 240); step(8'h0C, 8'h00);
    check_eq("spr_g", {30'd0, uo_out[1], uo_out[5]}, 32'h3);
    check_eq("spr_rb", {24'd0, uo_out & 8'h55}, 32'h0);
    jump(288, 208); step(8'h0C, 8'h30);
    check_eq("spr_corner", {24'd0, uo_out & 8'h77}, 32'h11);
    jump(700, 100); step(8'h3F, 8'h3F);
    check_eq("blank", {24'd0, uo_out & 8'h77}, 32'h0);
    check_eq("uio_out", {24'd0, uio_out}, 32'h0);
    check_eq("uio_oe", {24'd0, uio_oe}, 32'h0);

    // random scans across the sprite at reset position
    jump(270, 200); run(100);
    jump(270, 230); run(100);
    jump(270, 270); run(100);

    // frame wrap and vsync width
    jump(790, 524); run(30);
    jump(700, 489);
    vs_low = 0;
    for (int k = 0; k < 1800; k++) begin
      step(8'($urandom), 8'($urandom));
      if (!uo_out[3]) vs_low++;
    end
    check_eq("vs_width", 32'(vs_low), 32'd1600);

    // motion, pause and bounce
    jump(790, 479); run_p(20, 1'b0);
    check_sprite("move", 289, 209, 1'b1, 1'b1);
    jump(280, 205); run(80);
    jump(340, 270); run(80);
    jump(790, 479); run_p(20, 1'b1);
    check_sprite("pause", 289, 209, 1'b1, 1'b1);
    set_sprite(576, 416, 1'b1, 1'b1);
    jump(790, 479); run_p(20, 1'b0);
    check_sprite("bounce_hi", 575, 415, 1'b0, 1'b0);
    jump(560, 420); run(120);
    jump(560, 470); run(100);
    set_sprite(0, 0, 1'b0, 1'b0);
    jump(790, 479); run_p(20, 1'b0);
    check_sprite("bounce_lo", 1, 1, 1'b1, 1'b1);
    jump(0, 3); run(80);

    // asynchronous reset mid-line
    run(50);
    #7 rst_n = 1'b0;
    #1;
    check_eq("arst_uo", {24'd0, uo_out}, 32'h88);
    check_eq("arst_h", {22'd0, dut.u_timing.hcount_q}, 32'd0);
    check_sprite("arst", 288, 208, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(900);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
